dma_channel_arbiter: RTL and testbench

Registered multi-channel arbiter for the DMA engine. It selects one requesting channel per transaction, either round-robin or priority-with-round-robin-tiebreak, and holds the grant until the engine signals transaction completion. It counts data beats per grant and flags frame-size overruns so that no single channel monopolises the AXI master. It sits between the per-channel descriptor/register blocks and the AXI4 read/write engine.

---
 rtl/dma_channel_arbiter.sv | 151 +++++++++++++++
 tb/tb_dma_channel_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - registered DMA channel arbiter (round-robin or priority with round-robin tiebreak)
module dma_channel_arbiter #(
    parameter int C_NUM_CHANNELS           = 4,
    parameter int C_PRIORITY_WIDTH         = 3,
    parameter int C_TRANSACTION_SIZE_WIDTH = 32,
    parameter int C_FRAME_SIZE             = 256,
    parameter int C_MODE                   = 0,
    parameter int C_IDX_W                  = $clog2(C_NUM_CHANNELS)
) (
    input  logic                                               ACLK,
    input  logic                                               ARESETN,
    input  logic [C_NUM_CHANNELS-1:0]                          ch_req,
    input  logic [C_NUM_CHANNELS*C_PRIORITY_WIDTH-1:0]         ch_priority,
    input  logic [C_NUM_CHANNELS*C_TRANSACTION_SIZE_WIDTH-1:0] ch_xfer_size,
    input  logic                                               beat_done,
    input  logic                                               txn_done,
    output logic                                               grant_valid,
    output logic [C_NUM_CHANNELS-1:0]                          grant_onehot,
    output logic [C_IDX_W-1:0]                                 grant_idx,
    output logic [C_TRANSACTION_SIZE_WIDTH-1:0]                grant_xfer_size,
    output logic [C_TRANSACTION_SIZE_WIDTH-1:0]                grant_beats,
    output logic                                               frame_limit
);

    localparam int P = C_PRIORITY_WIDTH;
    localparam int T = C_TRANSACTION_SIZE_WIDTH;
    localparam logic [C_IDX_W:0]          NUM_W   = (C_IDX_W+1)'(C_NUM_CHANNELS);
    localparam logic [C_IDX_W-1:0]        LAST_RST = C_IDX_W'(C_NUM_CHANNELS - 1);
    localparam logic [T-1:0]              FRAME_T = T'(C_FRAME_SIZE);
    localparam logic [C_NUM_CHANNELS-1:0] ONE_HOT0 = C_NUM_CHANNELS'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_RELEASE
    } state_t;

    state_t                    state_q, state_d;
    logic [C_IDX_W-1:0]        last_q, last_d;
    logic [C_IDX_W-1:0]        idx_q, idx_d;
    logic [C_NUM_CHANNELS-1:0] onehot_q, onehot_d;
    logic                      valid_q, valid_d;
    logic [T-1:0]              xfer_q, xfer_d;
    logic [T-1:0]              beats_q, beats_d;
    logic                      frame_q, frame_d;

    logic [P-1:0]              prio_arr [C_NUM_CHANNELS];
    logic [T-1:0]              size_arr [C_NUM_CHANNELS];
    logic [C_IDX_W:0]          cand_w;
    logic [C_IDX_W-1:0]        cand;
    logic                      win_found;
    logic [C_IDX_W-1:0]        win_idx;
    logic [P-1:0]              win_prio;

    always_comb begin
        for (int i = 0; i < C_NUM_CHANNELS; i++) begin
            prio_arr[i] = ch_priority[i*P +: P];
            size_arr[i] = ch_xfer_size[i*T +: T];
        end
    end

    // Walk channels in round-robin order starting after last_q; in priority
    // mode only a strictly higher priority displaces an earlier candidate.
    always_comb begin
        cand_w    = '0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        for (int k = 1; k <= C_NUM_CHANNELS; k++) begin
            cand_w = {1'b0, last_q} + (C_IDX_W+1)'(k);
            if (cand_w >= NUM_W) begin
                cand_w = cand_w - NUM_W;
            end
            cand = cand_w[C_IDX_W-1:0];
            if (ch_req[cand]) begin
                if (!win_found || (C_MODE == 1 && prio_arr[cand] > win_prio)) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                    win_prio  = prio_arr[cand];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        xfer_d   = xfer_q;
        beats_d  = beats_q;
        case (state_q)
            ST_IDLE: begin
                if (|ch_req) begin
                    valid_d  = 1'b1;
                    idx_d    = win_idx;
                    onehot_d = ONE_HOT0 << win_idx;
                    xfer_d   = size_arr[win_idx];
                    beats_d  = '0;
                    state_d  = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (beat_done && beats_q != '1) begin
                    beats_d = beats_q + 1'b1;
                end
                if (txn_done) begin
                    last_d   = idx_q;
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        frame_d = (beats_d >= FRAME_T);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            last_q   <= LAST_RST;
            idx_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            xfer_q   <= '0;
            beats_q  <= '0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            xfer_q   <= xfer_d;
            beats_q  <= beats_d;
            frame_q  <= frame_d;
        end
    end

    assign grant_valid     = valid_q;
    assign grant_onehot    = onehot_q;
    assign grant_idx       = idx_q;
    assign grant_xfer_size = xfer_q;
    assign grant_beats     = beats_q;
    assign frame_limit     = frame_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - bench for dma_channel_arbiter, both modes against a reference model
module tb_dma_channel_arbiter;

    localparam int N = 4;
    localparam int P = 3;
    localparam int T = 32;
    localparam int F = 4;

    logic             ACLK;
    logic             ARESETN;
    logic [N-1:0]     ch_req;
    logic [N*P-1:0]   ch_priority;
    logic [N*T-1:0]   ch_xfer_size;
    logic             beat_done;
    logic             txn_done;

    logic             gv   [2];
    logic [N-1:0]     goh  [2];
    logic [1:0]       gidx [2];
    logic [T-1:0]     gxs  [2];
    logic [T-1:0]     gb   [2];
    logic             fl   [2];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: 0 idle, 1 granted, 2 release
    int      m_phase [2];
    int      m_last  [2];
    int      m_idx   [2];
    bit      m_valid [2];
    longint  m_xfer  [2];
    longint  m_beats [2];

    dma_channel_arbiter #(
        .C_NUM_CHANNELS(N), .C_PRIORITY_WIDTH(P), .C_TRANSACTION_SIZE_WIDTH(T),
        .C_FRAME_SIZE(F), .C_MODE(0)
    ) u_dut_rr (
        .ACLK(ACLK), .ARESETN(ARESETN), .ch_req(ch_req), .ch_priority(ch_priority),
        .ch_xfer_size(ch_xfer_size), .beat_done(beat_done), .txn_done(txn_done),
        .grant_valid(gv[0]), .grant_onehot(goh[0]), .grant_idx(gidx[0]),
        .grant_xfer_size(gxs[0]), .grant_beats(gb[0]), .frame_limit(fl[0])
    );

    dma_channel_arbiter #(
        .C_NUM_CHANNELS(N), .C_PRIORITY_WIDTH(P), .C_TRANSACTION_SIZE_WIDTH(T),
        .C_FRAME_SIZE(F), .C_MODE(1)
    ) u_dut_prio (
        .ACLK(ACLK), .ARESETN(ARESETN), .ch_req(ch_req), .ch_priority(ch_priority),
        .ch_xfer_size(ch_xfer_size), .beat_done(beat_done), .txn_done(txn_done),
        .grant_valid(gv[1]), .grant_onehot(goh[1]), .grant_idx(gidx[1]),
        .grant_xfer_size(gxs[1]), .grant_beats(gb[1]), .frame_limit(fl[1])
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int prio_of(input int ch);
        logic [N*P-1:0] v;
        v = ch_priority;
        return int'(v[ch*P +: P]);
    endfunction

    // Mode 0: first requester after last. Mode 1: find the top priority among
    // requesters, then take the first requester holding it after last.
    function automatic int pick(input int mode, input int last);
        int top;
        top = -1;
        if (mode == 1) begin
            for (int c = 0; c < N; c++) begin
                if (ch_req[c] && prio_of(c) > top) top = prio_of(c);
            end
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (ch_req[c] && (mode == 0 || prio_of(c) == top)) return c;
        end
        return -1;
    endfunction

    task automatic model_update();
        logic [N*T-1:0] sz;
        sz = ch_xfer_size;
        for (int k = 0; k < 2; k++) begin
            if (!ARESETN) begin
                m_phase[k] = 0; m_last[k] = N - 1; m_idx[k] = 0;
                m_valid[k] = 0; m_xfer[k] = 0;     m_beats[k] = 0;
            end else if (m_phase[k] == 0) begin
                if (ch_req != '0) begin
                    m_idx[k]   = pick(k, m_last[k]);
                    m_valid[k] = 1;
                    m_xfer[k]  = longint'(sz[m_idx[k]*T +: T]);
                    m_beats[k] = 0;
                    m_phase[k] = 1;
                end
            end else if (m_phase[k] == 1) begin
                if (beat_done && m_beats[k] < 64'hFFFF_FFFF) m_beats[k]++;
                if (txn_done) begin
                    m_last[k]  = m_idx[k];
                    m_valid[k] = 0;
                    m_phase[k] = 2;
                end
            end else begin
                m_phase[k] = 0;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge ACLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("valid%0d", k), 64'(gv[k]), 64'(m_valid[k]));
            check($sformatf("onehot%0d", k), 64'(goh[k]), m_valid[k] ? (64'd1 << m_idx[k]) : 64'd0);
            check($sformatf("idx%0d", k), 64'(gidx[k]), 64'(m_idx[k]));
            check($sformatf("xfer%0d", k), 64'(gxs[k]), m_xfer[k]);
            check($sformatf("beats%0d", k), 64'(gb[k]), m_beats[k]);
            check($sformatf("frame%0d", k), 64'(fl[k]), 64'(m_beats[k] >= F));
        end
    endtask

    task automatic wait_grant(output int waited);
        waited = 0;
        while (gv[0] !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        check("grant_seen", 64'(gv[0]), 64'd1);
    endtask

    task automatic do_txn(input logic [N-1:0] req, input int nbeats, input bit merge,
                          input bit perturb, input int exp0, input int exp1, input int exp_wait);
        int waited;
        logic [T-1:0] held_size;
        logic [N*T-1:0] sz;
        ch_req = req; beat_done = 0; txn_done = 0;
        wait_grant(waited);
        if (exp_wait >= 0) check("grant_wait", 64'(waited), 64'(exp_wait));
        check("grant_idx_rr", 64'(gidx[0]), 64'(exp0));
        check("grant_idx_prio", 64'(gidx[1]), 64'(exp1));
        sz = ch_xfer_size;
        held_size = sz[exp0*T +: T];
        if (perturb) begin
            ch_req       = 4'b0001;
            ch_xfer_size = {$urandom, $urandom, $urandom, $urandom};
            ch_priority  = 12'o7777;
        end
        for (int i = 0; i < nbeats; i++) begin
            beat_done = 1;
            txn_done  = merge && (i == nbeats - 1);
            step();
            if (!(merge && i == nbeats - 1)) begin
                check("beat_count", 64'(gb[0]), 64'(i + 1));
                check("frame_edge", 64'(fl[0]), 64'((i + 1) >= F));
            end
        end
        beat_done = 0;
        if (!merge) begin
            repeat (2) step();
            check("held_valid", 64'(gv[0]), 64'd1);
            check("held_idx", 64'(gidx[0]), 64'(exp0));
            check("held_size", 64'(gxs[0]), 64'(held_size));
            txn_done = 1;
            step();
        end
        txn_done = 0;
        check("released", 64'(gv[0]), 64'd0);
        check("final_beats", 64'(gb[0]), 64'(nbeats));
    endtask

    initial begin
        int waited;
        logic [31:0] r;
        ARESETN = 0; ch_req = '0; ch_priority = '0; beat_done = 0; txn_done = 0;
        ch_xfer_size = {32'd400, 32'd300, 32'd200, 32'd100};
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_last[k] = N - 1; m_idx[k] = 0;
            m_valid[k] = 0; m_xfer[k] = 0; m_beats[k] = 0;
        end
        step();
        step();
        check("rst_valid", 64'(gv[0]), 64'd0);
        check("rst_onehot", 64'(goh[1]), 64'd0);
        check("rst_idx", 64'(gidx[0]), 64'd0);
        check("rst_size", 64'(gxs[1]), 64'd0);
        ARESETN = 1;

        // round-robin over all four channels
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 0, 0, 0, i % N, i % N, (i == 0) ? 1 : 2);
        end

        // priority with ties, after ch1 was last granted
        do_txn(4'b0010, 0, 0, 0, 1, 1, 2);
        ch_priority = {3'd5, 3'd0, 3'd5, 3'd2};
        do_txn(4'b1011, 0, 0, 0, 3, 3, 2);
        do_txn(4'b1011, 0, 0, 0, 0, 1, 2);
        do_txn(4'b0001, 0, 0, 0, 0, 0, 2);

        // mid-grant request/size changes are ignored
        ch_priority = '0;
        do_txn(4'b0100, 0, 0, 1, 2, 2, 2);

        // frame quota and beat counting
        ch_priority = '0;
        do_txn(4'b1000, 6, 0, 0, 3, 3, 2);

        // beat and txn in the same cycle, then stray strobes while idle
        do_txn(4'b0001, 3, 1, 0, 0, 0, 2);
        ch_req = '0;
        step();
        txn_done = 1; step(); txn_done = 0;
        beat_done = 1; step(); beat_done = 0;
        check("stray_ignored", 64'(gv[0]), 64'd0);

        // reset mid-grant
        ch_req = 4'b0100;
        wait_grant(waited);
        beat_done = 1;
        repeat (5) step();
        beat_done = 0;
        check("pre_rst_beats", 64'(gb[0]), 64'd5);
        ARESETN = 0;
        step();
        ARESETN = 1;
        check("mid_rst_valid", 64'(gv[0]), 64'd0);
        check("mid_rst_beats", 64'(gb[0]), 64'd0);
        check("mid_rst_idx", 64'(gidx[1]), 64'd0);
        check("mid_rst_frame", 64'(fl[0]), 64'd0);
        do_txn(4'b1111, 0, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            ch_req = r[3:0];
            ch_priority = r[31] ? r[15:4] : (r[15:4] & 12'o5555);
            if (r[20:18] == 3'd0) ch_xfer_size = {$urandom, $urandom, $urandom, $urandom};
            beat_done = r[16];
            txn_done  = (r[24:22] < 3'd2);
            ARESETN   = (r[30:25] != 6'd0) || (i % 7 != 0);
            step();
        end
        ARESETN = 1; beat_done = 0; txn_done = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
